// File: rtl/final_project_soc_pio_out_blink.sv
// rtl/final_project_soc_pio_out_blink.sv - Avalon-MM output PIO with SET/CLEAR/TOGGLE aliases and per-bit blink
module final_project_soc_pio_out_blink #(
  parameter int unsigned       WIDTH       = 18,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       DIV_W       = 24,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_blink_en;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;

  logic             w_wr;
  logic             w_div_wr;
  logic [WIDTH-1:0] w_wd;
  logic [DIV_W-1:0] w_wd_div;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_div_wr = w_wr && (address == 3'd5);
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_wd_div = writedata[DIV_W-1:0];
  assign w_unused = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_div      <= DEFAULT_DIV;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_data     <= w_wd;
        3'd1:    r_data     <= r_data | w_wd;
        3'd2:    r_data     <= r_data & ~w_wd;
        3'd3:    r_data     <= r_data ^ w_wd;
        3'd4:    r_blink_en <= w_wd;
        3'd5:    r_div      <= w_wd_div;
        default: ;
      endcase
    end
  end

  // A BLINK_DIV write restarts the blink cycle and beats a same-cycle terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= DEFAULT_DIV;
      r_phase <= 1'b1;
    end else if (w_div_wr) begin
      r_cnt   <= w_wd_div;
      r_phase <= 1'b1;
    end else if (r_div == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - DIV_W'(1);
    end else begin
      r_cnt   <= r_div;
      r_phase <= ~r_phase;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3: readdata[WIDTH-1:0] = r_data;
      3'd4:                   readdata[WIDTH-1:0] = r_blink_en;
      3'd5:                   readdata[DIV_W-1:0] = r_div;
      3'd6:                   readdata[0]         = r_phase;
      default:                ;
    endcase
  end

  assign out_port = r_data & (~r_blink_en | {WIDTH{r_phase}});

endmodule

// File: tb/tb_final_project_soc_pio_out_blink.sv
// tb/tb_final_project_soc_pio_out_blink.sv - directed scoreboard bench for the blinking output PIO
module tb_final_project_soc_pio_out_blink;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] out_port;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  final_project_soc_pio_out_blink #(
    .WIDTH(18), .RESET_VALUE(18'h2A5A5), .DIV_W(24), .DEFAULT_DIV(24'd0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    push(32'h0002A5A5); check("rst_out", 32'(out_port));
    push(32'h0002A5A5); rd(3'd0, v); check("rst_data", v);
    push(32'd1);        rd(3'd6, v); check("rst_status", v);
    push(32'd0);        rd(3'd4, v); check("rst_blink_en", v);
    push(32'd0);        rd(3'd5, v); check("rst_div", v);

    // set / clear / toggle aliases
    wr(3'd0, 32'h0);        push(32'h0);  check("data0_out", 32'(out_port));
    wr(3'd1, 32'hFFFC0011); push(32'h11); check("set_out", 32'(out_port));
    push(32'h11); rd(3'd1, v); check("set_rd", v);
    wr(3'd2, 32'h01);       push(32'h10); check("clr_out", 32'(out_port));
    wr(3'd3, 32'h30);       push(32'h20); check("tgl_out", 32'(out_port));
    push(32'h20); rd(3'd3, v); check("tgl_rd", v);

    // blink bit0 with half-period 4
    wr(3'd0, 32'h3);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'd3);
    address = 3'd6; #1;
    for (int k = 0; k < 16; k++) begin
      logic ph;
      ph = ((k / 4) % 2) == 0;
      push({30'd0, 1'b1, ph}); check("blink_out", 32'(out_port));
      push({31'd0, ph});       check("blink_status", readdata);
      tick();
    end

    // BLINK_DIV=0 freezes phase at 1 even with all bits blink-enabled
    wr(3'd5, 32'd0);
    wr(3'd4, 32'h3FFFF);
    address = 3'd6; #1;
    for (int k = 0; k < 100; k++) begin
      push(32'h3); check("halt_out", 32'(out_port));
      push(32'h1); check("halt_status", readdata);
      tick();
    end

    // BLINK_DIV rewrite mid-blink restarts at phase 1
    wr(3'd4, 32'h1);
    wr(3'd5, 32'd3);
    repeat (5) tick();
    address = 3'd6; #1;
    push(32'h0); check("mid_phase0", readdata);
    wr(3'd5, 32'd5);
    address = 3'd6; #1;
    for (int k = 0; k < 8; k++) begin
      logic ph;
      ph = (k < 6);
      push({31'd0, ph});       check("reload_status", readdata);
      push({30'd0, 1'b1, ph}); check("reload_out", 32'(out_port));
      tick();
    end

    // reset mid-blink
    reset = 1'b1; tick(); reset = 1'b0;
    push(32'h0002A5A5); check("rst2_out", 32'(out_port));
    push(32'd0);        rd(3'd4, v); check("rst2_blink_en", v);
    push(32'd0);        rd(3'd5, v); check("rst2_div", v);
    push(32'd1);        rd(3'd6, v); check("rst2_status", v);

    // reserved / read-only addresses and non-strobes
    push(32'd0); rd(3'd7, v); check("rsvd_rd", v);
    wr(3'd7, 32'hFFFFFFFF);
    wr(3'd6, 32'hFFFFFFFF);
    push(32'h0002A5A5); rd(3'd0, v); check("rsvd_wr_data", v);
    push(32'd0);        rd(3'd4, v); check("rsvd_wr_en", v);
    push(32'd0);        rd(3'd5, v); check("rsvd_wr_div", v);
    @(negedge clk);
    address = 3'd0; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
    tick();
    chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    push(32'h0002A5A5); check("nocs_out", 32'(out_port));
    push(32'h0002A5A5); rd(3'd0, v); check("nocs_data", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
